// File: rtl/proc_sequencer.sv
// proc_sequencer: four-state instruction sequencer (FETCH/DECODE/EXECUTE/WRITEBACK)
// advanced by a tick that comes from a free-run prescaler or from single-step requests.
module proc_sequencer #(
    parameter int unsigned ROM_SIZE = 16,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic [15:0] instruction,
    input  logic        alu_zero,
    input  logic [15:0] data_a,
    output logic [3:0]  pc,
    output logic [15:0] ir,
    output logic        write_enable,
    output logic        wb_sel,
    output logic        zero_flag,
    output logic [7:0]  out_value,
    output logic [1:0]  state
);

    localparam int unsigned PC_W  = 4;
    localparam int unsigned IR_W  = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned CNT_W = 32;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(ROM_SIZE - 1);

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BR  = 4'hC;
    localparam logic [3:0] OP_OUT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_e;

    state_e            cur_state;
    state_e            nxt_state;
    logic [CNT_W-1:0]  presc_cnt;
    logic              step_q;
    logic              step_pulse;
    logic              tick_c;
    logic [3:0]        opcode_c;
    logic [PC_W-1:0]   jmp_addr_c;
    logic [PC_W-1:0]   pc_inc_c;
    logic              is_write_c;
    logic              unused_data_hi;

    // Upper byte of read port A is never displayed.
    assign unused_data_hi = ^data_a[15:8];

    assign opcode_c   = ir[15:12];
    assign jmp_addr_c = ir[11:8];
    assign pc_inc_c   = (pc == PC_LAST) ? '0 : pc + PC_W'(1);
    assign is_write_c = (opcode_c == OP_LDI) || (opcode_c == OP_ADD) || (opcode_c == OP_SUB);
    assign state      = cur_state;

    // Prescaler: counts only while running; held at 0 otherwise so any run edge restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (!run) begin
            presc_cnt <= '0;
        end else if (presc_cnt == CNT_LAST) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + CNT_W'(1);
        end
    end

    // Step edge detector: one registered pulse per 0->1 step edge while stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q     <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_q     <= step;
            step_pulse <= step & ~step_q & ~run;
        end
    end

    // Tick source selection.
    always_comb begin
        tick_c = 1'b0;
        if (run) begin
            tick_c = (presc_cnt == CNT_LAST);
        end else begin
            tick_c = step_pulse;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // FSM next state: one step around the ring per tick.
    always_comb begin
        nxt_state = cur_state;
        if (tick_c) begin
            case (cur_state)
                S_FETCH:     nxt_state = S_DECODE;
                S_DECODE:    nxt_state = S_EXECUTE;
                S_EXECUTE:   nxt_state = S_WRITEBACK;
                S_WRITEBACK: nxt_state = S_FETCH;
                default:     nxt_state = S_FETCH;
            endcase
        end
    end

    // Datapath registers updated on the tick of the relevant state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            ir           <= '0;
            write_enable <= 1'b0;
            wb_sel       <= 1'b0;
            zero_flag    <= 1'b0;
            out_value    <= '0;
        end else begin
            write_enable <= 1'b0;
            if (tick_c) begin
                case (cur_state)
                    S_FETCH: begin
                        ir <= IR_W'(instruction);
                    end
                    S_EXECUTE: begin
                        write_enable <= is_write_c;
                        wb_sel       <= (opcode_c == OP_ADD) || (opcode_c == OP_SUB);
                        if (opcode_c == OP_SUB) begin
                            zero_flag <= alu_zero;
                        end
                        if (opcode_c == OP_OUT) begin
                            out_value <= OUT_W'(data_a[7:0]);
                        end
                    end
                    S_WRITEBACK: begin
                        if (opcode_c == OP_JMP) begin
                            pc <= jmp_addr_c;
                        end else if ((opcode_c == OP_BR) && zero_flag) begin
                            pc <= jmp_addr_c;
                        end else begin
                            pc <= pc_inc_c;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: a fast instance (TICK_DIV=1) runs a
// table of instructions; a slow instance (TICK_DIV=10) checks tick spacing.
module tb_proc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Fast instance
    logic        rst, run, step, alu_zero;
    logic [15:0] data_a, instruction;
    logic [3:0]  pc;
    logic [15:0] ir;
    logic        write_enable, wb_sel, zero_flag;
    logic [7:0]  out_value;
    logic [1:0]  state;
    logic [15:0] rom [16];

    assign instruction = rom[pc];

    proc_sequencer #(.ROM_SIZE(16), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .instruction(instruction),
        .alu_zero(alu_zero), .data_a(data_a), .pc(pc), .ir(ir),
        .write_enable(write_enable), .wb_sel(wb_sel), .zero_flag(zero_flag),
        .out_value(out_value), .state(state)
    );

    // Slow instance
    logic        rst_s, run_s, step_s, az_s;
    logic [15:0] da_s, instr_s;
    logic [3:0]  pc_s;
    logic [15:0] ir_s;
    logic        we_s, wbs_s, zf_s;
    logic [7:0]  out_s;
    logic [1:0]  state_s;

    proc_sequencer #(.ROM_SIZE(16), .TICK_DIV(10)) dut10 (
        .clk(clk), .rst(rst_s), .run(run_s), .step(step_s), .instruction(instr_s),
        .alu_zero(az_s), .data_a(da_s), .pc(pc_s), .ir(ir_s),
        .write_enable(we_s), .wb_sel(wbs_s), .zero_flag(zf_s),
        .out_value(out_s), .state(state_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        az;
        logic [15:0] da;
        logic [3:0]  exp_pc;
        logic        exp_z;
        logic [7:0]  exp_out;
        logic        exp_we;
        logic        exp_wbsel;
    } vec_t;

    vec_t tbl [16];

    // Run one instruction on the fast instance (tick every cycle), starting in FETCH.
    task automatic exec(input vec_t v, input string tag);
        int   we_cnt;
        int   we_cyc;
        logic wbs;
        we_cnt = 0;
        we_cyc = 0;
        wbs    = 1'b0;
        check({tag, " start_state"}, 32'(state), 32'd0);
        rom[pc]  = v.instr;
        alu_zero = v.az;
        data_a   = v.da;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (write_enable) begin
                we_cnt++;
                we_cyc = c;
                wbs    = wb_sel;
            end
        end
        check({tag, " ir"}, 32'(ir), 32'(v.instr));
        check({tag, " pc"}, 32'(pc), 32'(v.exp_pc));
        check({tag, " state"}, 32'(state), 32'd0);
        check({tag, " zero_flag"}, 32'(zero_flag), 32'(v.exp_z));
        check({tag, " out_value"}, 32'(out_value), 32'(v.exp_out));
        check({tag, " we_count"}, 32'(we_cnt), v.exp_we ? 32'd1 : 32'd0);
        if (v.exp_we) begin
            check({tag, " we_cycle"}, 32'(we_cyc), 32'd3);
            check({tag, " wb_sel"}, 32'(wbs), 32'(v.exp_wbsel));
        end
    endtask

    // Wait (bounded) for the slow instance to change state; optionally pulse step meanwhile.
    task automatic wait_change_s(input logic pulse, output int n);
        logic [1:0] prev;
        prev = state_s;
        n    = 0;
        if (pulse) step_s = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            step_s = 1'b0;
            n++;
            if (state_s !== prev) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int         n;
        int         changes;
        logic [1:0] prev;

        //             instr     az    da        pc     z     out     we    wbsel
        tbl[0]  = '{16'h1205, 1'b0, 16'h0000, 4'd1,  1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{16'h2000, 1'b1, 16'h0000, 4'd2,  1'b0, 8'h00, 1'b1, 1'b1};
        tbl[2]  = '{16'h3000, 1'b1, 16'h0000, 4'd3,  1'b1, 8'h00, 1'b1, 1'b1};
        tbl[3]  = '{16'hC700, 1'b0, 16'h0000, 4'd7,  1'b1, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{16'h3000, 1'b0, 16'h0000, 4'd8,  1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5]  = '{16'hC200, 1'b0, 16'h0000, 4'd9,  1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{16'hF000, 1'b0, 16'h12AB, 4'd10, 1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[7]  = '{16'h0000, 1'b1, 16'h0033, 4'd11, 1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[8]  = '{16'h5123, 1'b1, 16'h0044, 4'd12, 1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[9]  = '{16'h8F00, 1'b0, 16'h0000, 4'd15, 1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[10] = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[11] = '{16'h8300, 1'b0, 16'h0000, 4'd3,  1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[12] = '{16'h8300, 1'b0, 16'h0000, 4'd3,  1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[13] = '{16'h8300, 1'b0, 16'h0000, 4'd3,  1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[14] = '{16'h8300, 1'b0, 16'h0000, 4'd3,  1'b0, 8'hAB, 1'b0, 1'b0};
        tbl[15] = '{16'h1F00, 1'b0, 16'h0000, 4'd4,  1'b0, 8'hAB, 1'b1, 1'b0};

        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rst = 1'b1; run = 1'b0; step = 1'b0; alu_zero = 1'b0; data_a = 16'h0000;
        rst_s = 1'b1; run_s = 1'b0; step_s = 1'b0; az_s = 1'b0;
        da_s = 16'h12AB; instr_s = 16'hF000;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst pc", 32'(pc), 32'd0);
        check("rst ir", 32'(ir), 32'd0);
        check("rst state", 32'(state), 32'd0);
        check("rst write_enable", 32'(write_enable), 32'd0);
        check("rst wb_sel", 32'(wb_sel), 32'd0);
        check("rst zero_flag", 32'(zero_flag), 32'd0);
        check("rst out_value", 32'(out_value), 32'd0);

        // Table-driven instruction stream, free-running with one tick per clk
        rst = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 16; i++) exec(tbl[i], $sformatf("vec%0d", i));

        // Step held high: exactly one advance
        run = 1'b0;
        rom[4] = 16'h0000;
        step = 1'b1;
        prev = state;
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if (state !== prev) changes++;
            prev = state;
        end
        step = 1'b0;
        check("step_hold advances", 32'(changes), 32'd1);
        check("step_hold state", 32'(state), 32'd1);
        repeat (3) @(negedge clk);

        // Three more separate pulses complete the instruction
        repeat (3) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("step_pulses state", 32'(state), 32'd0);
        check("step_pulses pc", 32'(pc), 32'd5);
        check("step_pulses ir", 32'(ir), 32'h0000);

        // Set flag and display, then reset inside the write_enable cycle
        run = 1'b1;
        exec('{16'h3000, 1'b1, 16'h0000, 4'd6, 1'b1, 8'hAB, 1'b1, 1'b1}, "pre_rst_sub");
        exec('{16'hF000, 1'b0, 16'h0055, 4'd7, 1'b1, 8'h55, 1'b0, 1'b0}, "pre_rst_out");
        rom[7] = 16'h1205;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("we_before_rst", 32'(write_enable), 32'd1);
        check("state_before_rst", 32'(state), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst write_enable", 32'(write_enable), 32'd0);
        check("mid_rst pc", 32'(pc), 32'd0);
        check("mid_rst ir", 32'(ir), 32'd0);
        check("mid_rst state", 32'(state), 32'd0);
        check("mid_rst zero_flag", 32'(zero_flag), 32'd0);
        check("mid_rst out_value", 32'(out_value), 32'd0);
        check("mid_rst wb_sel", 32'(wb_sel), 32'd0);
        rst = 1'b0;
        run = 1'b0;

        // Slow instance: tick spacing, step ignored while running, run drop freeze
        rst_s = 1'b0;
        run_s = 1'b1;
        wait_change_s(1'b0, n);
        check("div10 first_tick", 32'(n), 32'd10);
        check("div10 state1", 32'(state_s), 32'd1);
        wait_change_s(1'b1, n);
        check("div10 tick_with_step", 32'(n), 32'd10);
        check("div10 state2", 32'(state_s), 32'd2);
        repeat (4) @(negedge clk);
        run_s = 1'b0;
        prev = state_s;
        changes = 0;
        repeat (25) begin
            @(negedge clk);
            if (state_s !== prev) changes++;
            prev = state_s;
        end
        check("div10 frozen_changes", 32'(changes), 32'd0);
        check("div10 frozen_state", 32'(state_s), 32'd2);
        run_s = 1'b1;
        wait_change_s(1'b0, n);
        check("div10 restart_tick", 32'(n), 32'd10);
        check("div10 state3", 32'(state_s), 32'd3);
        check("div10 out_value", 32'(out_s), 32'h000000AB);
        wait_change_s(1'b0, n);
        check("div10 wb_tick", 32'(n), 32'd10);
        check("div10 pc", 32'(pc_s), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
